bht_update_ctrl: RTL
====================

# bht_update_ctrl

Sequencer and arbiter for the branch history table's write side. It merges branch-resolution updates from two requesters onto the table's single update port using round-robin arbitration and a small FIFO. It replaces the table's one-cycle bulk flush with a row-by-row clear sweep. It sits between the branch unit / commit logic and the frontend BHT.

## Interface
- NR_ROWS, 512, number of table rows swept on flush; power of two, ≥2
- FIFO_DEPTH, 4, update buffer entries; power of two, ≥2
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_req_i  in  1  request full-table clear
- debug_mode_i  in  1  when high, accepted updates are discarded
- req_a_valid_i / req_a_ready_o  in/out  1  requester A (branch unit) handshake
- req_a_pc_i  in  riscv::VLEN  branch PC
- req_a_taken_i  in  1  resolved direction
- req_b_valid_i / req_b_ready_o / req_b_pc_i / req_b_taken_i  same as A, requester B (replay/commit)
- upd_valid_o  out  1  registered update strobe to table; table always accepts
- upd_pc_o  out  riscv::VLEN  update PC
- upd_taken_o  out  1  update direction
- clr_valid_o  out  1  registered row-clear strobe
- clr_row_o  out  $clog2(NR_ROWS)  row to clear
- flush_busy_o  out  1  sweep in progress
- drop_cnt_o  out  16  saturating count of updates discarded in debug mode

## Operation
- States: IDLE, SWEEP. Reset → IDLE, FIFO empty, RR pointer favours A, all outputs 0, drop_cnt_o=0.
- Arbitration: if only one requester is valid, it is granted. If both are valid, the requester not granted at the last handshake wins. The pointer updates only on a handshake. At most one handshake per cycle. The non-granted ready is 0.
- Granted ready = space, where space = (count < FIFO_DEPTH) OR (state==IDLE AND count>0), because a simultaneous pop frees a slot. In debug mode, ready = grant regardless of space; the accepted update is discarded and drop_cnt_o increments, saturating at 0xFFFF.
- IDLE output register, loaded each cycle:
  - FIFO head if count>0; a same-cycle handshake is then enqueued.
  - Else the granted handshake (bypass).
  - Else upd_valid_o=0.
  - Ordering is strictly FIFO, oldest first.
- flush_req_i high in any cycle: at that edge the FIFO is emptied and the output register is cleared. Any handshake in that same cycle is also discarded (not counted). State → SWEEP, row counter=0.
- SWEEP:
  - clr_valid_o=1, clr_row_o=counter, counter+1 each cycle, upd_valid_o=0.
  - Handshakes are enqueued while count<FIFO_DEPTH; there is no draining.
  - After row NR_ROWS-1 → IDLE.
  - flush_req_i during SWEEP restarts the counter at 0 and empties the FIFO again.
- flush_busy_o = (state==SWEEP), registered.
- Reset asserted in any state: next cycle equals the post-reset condition; a partial sweep is abandoned.

## Timing
- Handshake in cycle N with empty FIFO in IDLE → upd_valid_o high in cycle N+1 for exactly one cycle.
- flush_req_i in cycle N (single pulse):
  - clr_valid_o, flush_busy_o high in cycles N+1..N+NR_ROWS, rows 0..NR_ROWS-1.
  - IDLE in N+NR_ROWS+1; buffered updates are emitted one per cycle from that cycle.
- upd_valid_o and clr_valid_o are never high in the same cycle.
- Ready is combinational from valids, state, count and debug_mode_i. Valid must not depend on ready.
- Throughput: one update per cycle in IDLE, sustained.

## Test plan
- A only: pc=0x8000_0010, taken=0 handshakes in cycle 5 → upd_valid_o=1, upd_pc_o=0x8000_0010, upd_taken_o=0 in cycle 6 only.
- A (pc 0x100) and B (pc 0x200) valid continuously from reset → grants A,B,A,B…; upd_pc_o sequence 0x100,0x200,0x100,0x200 on consecutive cycles.
- flush_req_i in cycle 10 with one update pending:
  - Pending update is never emitted.
  - Rows 0..511 are cleared in cycles 11..522.
  - B pushes 0x300, 0x304, 0x308, 0x30C during the sweep; the fifth request sees ready=0.
  - upd_pc_o emits 0x300..0x30C in cycles 523..526.
- flush_req_i re-pulsed when clr_row_o=100 → next cycle clr_row_o=0; sweep ends 512 cycles later; flush_busy_o stays high throughout.
- debug_mode_i=1, 3 A handshakes → ready=1, upd_valid_o stays 0, drop_cnt_o=3. Preload counter path to 0xFFFF; one more drop → stays 0xFFFF.
- rst_ni low for one cycle at clr_row_o=50 → next cycle state IDLE, clr_valid_o=0, flush_busy_o=0, FIFO empty, drop_cnt_o=0.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: round-robin merge of two BHT update requesters through a small FIFO, plus a row-by-row flush sweep
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   flush_req_i                 start (or restart) a full-table clear sweep
//   debug_mode_i                accepted updates are dropped and counted
//   req_{a,b}_valid_i/ready_o   requester handshakes, pc and taken payload
//   upd_valid_o/pc_o/taken_o    registered update strobe to the table
//   clr_valid_o/clr_row_o       registered row-clear strobe to the table
//   flush_busy_o                sweep in progress
//   drop_cnt_o                  saturating count of debug-mode drops
module bht_update_ctrl #(
  parameter int unsigned NR_ROWS    = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VLEN       = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_req_i,
  input  logic                       debug_mode_i,
  input  logic                       req_a_valid_i,
  output logic                       req_a_ready_o,
  input  logic [VLEN-1:0]            req_a_pc_i,
  input  logic                       req_a_taken_i,
  input  logic                       req_b_valid_i,
  output logic                       req_b_ready_o,
  input  logic [VLEN-1:0]            req_b_pc_i,
  input  logic                       req_b_taken_i,
  output logic                       upd_valid_o,
  output logic [VLEN-1:0]            upd_pc_o,
  output logic                       upd_taken_o,
  output logic                       clr_valid_o,
  output logic [$clog2(NR_ROWS)-1:0] clr_row_o,
  output logic                       flush_busy_o,
  output logic [15:0]                drop_cnt_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SWEEP} state_e;
  state_e state_q, state_d;
  logic prio_b_q;
  logic [PW:0] cnt_q;
  logic [PW-1:0] rd_q, wr_q;
  logic [VLEN-1:0] pc_mem [FIFO_DEPTH];
  logic taken_mem [FIFO_DEPTH];
  logic gnt_a, gnt_b, space, hs, hs_taken, load, pop, push;
  logic [VLEN-1:0] hs_pc;
  // prio_b_q is set once A wins a handshake, so B wins the next contested cycle
  assign gnt_a = req_a_valid_i & (~req_b_valid_i | ~prio_b_q);
  assign gnt_b = req_b_valid_i & ~gnt_a;
  // depth is a power of two, so the count MSB alone marks a full FIFO;
  // in IDLE a full FIFO still pops this cycle, freeing a slot
  assign space = ~cnt_q[PW] | (state_q == IDLE & cnt_q != '0);
  assign hs = req_a_ready_o | req_b_ready_o;
  assign hs_pc = gnt_a ? req_a_pc_i : req_b_pc_i;
  assign hs_taken = gnt_a ? req_a_taken_i : req_b_taken_i;
  // the output register loads whenever the next cycle is IDLE, so the first
  // IDLE cycle after a sweep already presents the oldest buffered update
  assign load = state_d == IDLE;
  assign pop = load & cnt_q != '0;
  assign push = hs & ~debug_mode_i & ~flush_req_i & ~(load & cnt_q == '0);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (flush_req_i | (state_q == SWEEP & ~&clr_row_o)) ? SWEEP : IDLE;
  end
  always_comb begin
    req_a_ready_o = gnt_a & (debug_mode_i | space);
    req_b_ready_o = gnt_b & (debug_mode_i | space);
    flush_busy_o = state_q == SWEEP;
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_q] <= hs_pc;
      taken_mem[wr_q] <= hs_taken;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_b_q <= 1'b0;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      upd_valid_o <= 1'b0;
      upd_pc_o <= '0;
      upd_taken_o <= 1'b0;
      clr_valid_o <= 1'b0;
      clr_row_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (hs) prio_b_q <= gnt_a;
      if (flush_req_i) begin
        cnt_q <= '0;
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      end
      upd_valid_o <= load & (pop | (hs & ~debug_mode_i));
      upd_pc_o <= pop ? pc_mem[rd_q] : hs_pc;
      upd_taken_o <= pop ? taken_mem[rd_q] : hs_taken;
      clr_valid_o <= state_d == SWEEP;
      clr_row_o <= (state_d == SWEEP & ~flush_req_i) ? clr_row_o + 1'b1 : '0;
      if (hs & debug_mode_i & ~flush_req_i & ~&drop_cnt_o) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
endmodule
